// File: rtl/puf_response_reader_pkg.sv
// ---------------------------------------------------------------------------
// puf_response_reader_pkg : shared state encoding and sizing helpers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package puf_response_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } puf_rd_state_t;

  localparam int SYNC_STAGES = 2;

  // Width of a counter that must hold the values 0..n without wrapping.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/puf_response_reader_if.sv
// ---------------------------------------------------------------------------
// puf_response_reader_if : challenge request and response handshake bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface puf_response_reader_if #(
  parameter int CHAL_W = 64
);
  logic [CHAL_W-1:0] chal;
  logic              chal_valid;
  logic              chal_ready;
  logic              resp;
  logic              unstable;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output chal, chal_valid, resp_ready,
    input  chal_ready, resp, unstable, resp_valid
  );

  modport slave (
    input  chal, chal_valid, resp_ready,
    output chal_ready, resp, unstable, resp_valid
  );
endinterface

`default_nettype wire

// File: rtl/puf_response_reader_sync2.sv
// ---------------------------------------------------------------------------
// puf_response_reader_sync2 : flop chain bringing the arbiter latch into clk
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module puf_response_reader_sync2
  import puf_response_reader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/puf_response_reader.sv
// ---------------------------------------------------------------------------
// puf_response_reader : drives arbiter-PUF races and majority-votes the result
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module puf_response_reader
  import puf_response_reader_pkg::*;
#(
  parameter int CHAL_W     = 64,
  parameter int SETTLE_CYC = 8,
  parameter int NUM_EVAL   = 7
) (
  input  logic                clk,
  input  logic                rst,
  puf_response_reader_if.slave bus,
  output logic [CHAL_W-1:0]   chain_sel,
  output logic                launch,
  input  logic                arb,
  output logic                busy
);

  localparam int SW = cnt_w(SETTLE_CYC);
  localparam int EW = cnt_w(NUM_EVAL);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(1);
  localparam logic [EW-1:0] EVAL_ALL    = EW'(NUM_EVAL);
  localparam logic [EW-1:0] EVAL_HALF   = EW'(NUM_EVAL / 2);

  if ((NUM_EVAL < 1) || ((NUM_EVAL % 2) == 0)) begin : g_bad_num_eval
    $error("puf_response_reader: NUM_EVAL must be odd and >= 1");
  end
  if (SETTLE_CYC < 1) begin : g_bad_settle
    $error("puf_response_reader: SETTLE_CYC must be >= 1");
  end

  puf_rd_state_t state;
  logic [SW-1:0] settle_cnt;
  logic [EW-1:0] ones_cnt;
  logic [EW-1:0] eval_cnt;
  logic [EW-1:0] eval_nxt;
  logic          arb_sync;

  puf_response_reader_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (arb),
    .q   (arb_sync)
  );

  assign eval_nxt = eval_cnt + EW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      chain_sel      <= '0;
      launch         <= 1'b0;
      busy           <= 1'b0;
      settle_cnt     <= '0;
      ones_cnt       <= '0;
      eval_cnt       <= '0;
      bus.chal_ready <= 1'b0;
      bus.resp       <= 1'b0;
      bus.unstable   <= 1'b0;
      bus.resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.chal_ready <= 1'b1;
          if (bus.chal_valid && bus.chal_ready) begin
            chain_sel      <= bus.chal;
            ones_cnt       <= '0;
            eval_cnt       <= '0;
            busy           <= 1'b1;
            bus.chal_ready <= 1'b0;
            state          <= ST_APPLY;
          end
        end

        ST_APPLY: begin
          settle_cnt <= '0;
          launch     <= 1'b1;
          state      <= ST_LAUNCH;
        end

        ST_LAUNCH: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        // launch stays high here so the race result has crossed the synchroniser
        ST_SAMPLE: begin
          if (settle_cnt == SAMPLE_LAST) begin
            ones_cnt   <= ones_cnt + EW'(arb_sync);
            settle_cnt <= '0;
            launch     <= 1'b0;
            state      <= ST_RECOVER;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        ST_RECOVER: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            eval_cnt   <= eval_nxt;
            if (eval_nxt == EVAL_ALL) begin
              bus.resp       <= (ones_cnt > EVAL_HALF);
              bus.unstable   <= (ones_cnt != '0) && (ones_cnt != EVAL_ALL);
              bus.resp_valid <= 1'b1;
              state          <= ST_DONE;
            end else begin
              launch <= 1'b1;
              state  <= ST_LAUNCH;
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

        // Ready is raised on exit so the next challenge can be taken one cycle later
        ST_DONE: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.chal_ready <= 1'b1;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end
        end

        default: begin
          launch <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_puf_response_reader.sv
// ---------------------------------------------------------------------------
// tb_puf_response_reader : directed self-checking bench for puf_response_reader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_puf_response_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter DUT
  puf_response_reader_if #(.CHAL_W(64)) bus ();
  logic [63:0] sel;
  logic        launch;
  logic        arb = 1'b0;
  logic        busy;

  puf_response_reader #(.CHAL_W(64), .SETTLE_CYC(8), .NUM_EVAL(7)) dut (
    .clk(clk), .rst(rst), .bus(bus), .chain_sel(sel),
    .launch(launch), .arb(arb), .busy(busy)
  );

  // Minimal DUT: one race, one settle cycle
  puf_response_reader_if #(.CHAL_W(8)) bus2 ();
  logic [7:0] sel2;
  logic       launch2;
  logic       arb2 = 1'b0;
  logic       busy2;

  puf_response_reader #(.CHAL_W(8), .SETTLE_CYC(1), .NUM_EVAL(1)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .chain_sel(sel2),
    .launch(launch2), .arb(arb2), .busy(busy2)
  );

  int errors = 0;
  int checks = 0;

  // Arbiter model: race k of the current challenge returns votes[k]
  logic [6:0] votes = 7'h00;
  logic       vote2 = 1'b0;
  int         launch_pulses = 0;
  int         race_base = 0;

  always @(posedge launch) begin
    arb = votes[(launch_pulses - race_base) % 7];
    launch_pulses = launch_pulses + 1;
  end

  always @(posedge launch2) arb2 = vote2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_chal(input string tag, input logic [63:0] c, input logic [6:0] v);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.chal_ready) break;
    end
    check({tag, "_ready"}, bus.chal_ready, 1);
    votes          = v;
    race_base      = launch_pulses;
    bus.chal       = c;
    bus.chal_valid = 1'b1;
    @(posedge clk);
    #1 bus.chal_valid = 1'b0;
    check({tag, "_sel"}, sel, c);
  endtask

  task automatic finish_chal(input string tag, input int exp_lat, input logic exp_resp,
                             input logic exp_unst);
    int lat = 0;
    while (!bus.resp_valid && lat < 400) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_resp"}, bus.resp, exp_resp);
    check({tag, "_unstable"}, bus.unstable, exp_unst);
    check({tag, "_pulses"}, launch_pulses - race_base, 7);
  endtask

  task automatic take_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.resp_valid, 0);
    check({tag, "_idle"}, {busy, bus.chal_ready}, 2'b01);
  endtask

  initial begin
    int acc_cyc, resp_cyc, n_acc, n_resp, lat2;

    bus.chal = '0;  bus.chal_valid = 1'b0;  bus.resp_ready = 1'b0;
    bus2.chal = '0; bus2.chal_valid = 1'b0; bus2.resp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {bus.chal_ready, bus.resp_valid, bus.resp, bus.unstable, launch, busy},
          6'b0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready_low_at_release", bus.chal_ready, 0);
    @(posedge clk);
    #1 check("rst_ready_after_release", bus.chal_ready, 1);

    // 1: consistent arbiter, XOR-reduce of 64'h1 is 1 on every race
    start_chal("t1", 64'h1, 7'h7F);
    finish_chal("t1", 127, 1'b1, 1'b0);
    take_resp("t1");

    // 2: mixed votes 1,0,1,1,0,0,1 (4 ones) and 0,0,0,1,1,0,0 (2 ones)
    start_chal("t2a", 64'hDEAD_BEEF_0123_4567, 7'b1001101);
    finish_chal("t2a", 127, 1'b1, 1'b1);
    take_resp("t2a");
    start_chal("t2b", 64'h0F0F_0000_FFFF_1234, 7'b0011000);
    finish_chal("t2b", 127, 1'b0, 1'b1);
    take_resp("t2b");

    // 3: consumer stalls 20 cycles in DONE while new requests are attempted
    start_chal("t3", 64'hA5A5_A5A5_5A5A_5A5A, 7'h00);
    finish_chal("t3", 127, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.chal       = 64'h1111_2222_3333_4444;
      bus.chal_valid = i[0];
      @(posedge clk);
      #1;
      check("t3_hold_valid", bus.resp_valid, 1);
      check("t3_hold_resp", {bus.resp, bus.unstable}, 2'b00);
      check("t3_hold_ready", bus.chal_ready, 0);
      check("t3_hold_sel", sel, 64'hA5A5_A5A5_5A5A_5A5A);
    end
    bus.chal_valid = 1'b0;
    take_resp("t3");

    // 4: reset during the third LAUNCH phase
    start_chal("t4", 64'h0000_0000_0000_0007, 7'h7F);
    for (int i = 0; i < 300 && (launch_pulses - race_base) < 3; i++) @(negedge clk);
    check("t4_third_launch", launch, 1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_launch", launch, 0);
    check("t4_rst_outputs", {bus.chal_ready, bus.resp_valid, bus.resp, bus.unstable, busy},
          5'b0);
    check("t4_rst_sel", sel, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("t4_ready_after_release", bus.chal_ready, 1);
    start_chal("t4b", 64'h0000_0000_0000_0003, 7'b1001101);
    finish_chal("t4b", 127, 1'b1, 1'b1);
    take_resp("t4b");

    // 5: back-to-back with valid and ready both held high
    votes     = 7'h7F;
    race_base = launch_pulses;
    bus.chal  = 64'h8000_0000_0000_0001;
    @(negedge clk);
    bus.chal_valid = 1'b1;
    bus.resp_ready = 1'b1;
    n_acc = 0; n_resp = 0; acc_cyc = 0; resp_cyc = 0;
    for (int cyc = 0; cyc < 600 && n_resp < 2; cyc++) begin
      @(negedge clk);
      if (bus.chal_ready) begin
        n_acc++;
        acc_cyc = cyc;
        if (n_acc == 2) check("t5_accept_gap", acc_cyc - resp_cyc, 1);
      end
      if (bus.resp_valid) begin
        n_resp++;
        resp_cyc = cyc;
        check("t5_pulses", launch_pulses - race_base, 7 * n_resp);
        check("t5_resp", {bus.resp, bus.unstable}, 2'b10);
      end
    end
    bus.chal_valid = 1'b0;
    check("t5_responses", n_resp, 2);
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    check("t5_idle", {busy, bus.chal_ready}, 2'b01);

    // 6: SETTLE_CYC=1, NUM_EVAL=1 instance
    for (int k = 0; k < 2; k++) begin
      vote2 = (k == 0);
      @(negedge clk);
      check("t6_ready", bus2.chal_ready, 1);
      bus2.chal       = 8'hA5 ^ 8'(k);
      bus2.chal_valid = 1'b1;
      @(posedge clk);
      #1 bus2.chal_valid = 1'b0;
      lat2 = 0;
      while (!bus2.resp_valid && lat2 < 50) begin
        @(posedge clk);
        #1 lat2++;
      end
      check("t6_latency", lat2, 5);
      check("t6_resp", bus2.resp, vote2);
      check("t6_unstable", bus2.unstable, 0);
      bus2.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus2.resp_ready = 1'b0;
      check("t6_valid_drop", bus2.resp_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
